dip_repl_unit: RTL and testbench

Parametrised dynamic-insertion replacement controller for the N-way set-associative data cache. It keeps true-LRU age state per set, chooses the victim way on a miss, and tracks hits to refresh recency. On each fill it decides where the new line enters the recency order, using set dueling between LRU and Bimodal Insertion (BIP) with a saturating PSEL counter. It sits beside the cache tag/data banks and is driven by the cache FSM: hits from the READY state, victim requests on a miss, fill commit on the last refill word.

---
 rtl/dip_repl_unit_pkg.sv | 25 ++
 rtl/dip_repl_unit_lru_age_set.sv | 50 +++++
 rtl/dip_repl_unit.sv | 182 ++++++++++++++++++
 tb/tb_dip_repl_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dip_repl_unit_pkg.sv
// Shared types and helpers for the dynamic-insertion replacement controller.
// Set classification for set dueling and the PSEL reset value.
package repl_pkg;

    typedef enum logic [1:0] {
        SET_FOLLOWER,
        SET_LEADER_LRU,
        SET_LEADER_BIP
    } SetClass;

    // Low LEADER_BITS of the index pick the dueling role of a set.
    function automatic SetClass set_class(input logic [31:0] index,
                                          input int          leader_bits);
        logic [31:0] low;
        low = index & ((32'd1 << leader_bits) - 32'd1);
        if (low == 32'd0) return SET_LEADER_LRU;
        if (low == 32'd1) return SET_LEADER_BIP;
        return SET_FOLLOWER;
    endfunction

    function automatic logic [31:0] psel_reset(input int width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/dip_repl_unit_lru_age_set.sv
// Combinational true-LRU age arithmetic for one set: touch-to-MRU,
// insert-at-LRU and locating the current LRU way.
module lru_age_set #(
    parameter int WAYS     = 4,
    parameter int WAY_BITS = 2
) (
    input  logic [WAYS*WAY_BITS-1:0] ages_i,
    input  logic [WAY_BITS-1:0]      way_i,
    output logic [WAYS*WAY_BITS-1:0] touch_o,
    output logic [WAYS*WAY_BITS-1:0] insert_lru_o,
    output logic [WAY_BITS-1:0]      lru_way_o
);

    localparam logic [WAY_BITS-1:0] AGE_LRU = WAY_BITS'(WAYS - 1);
    localparam logic [WAY_BITS-1:0] ONE     = WAY_BITS'(1);

    logic [WAY_BITS-1:0] ref_age;
    logic [WAY_BITS-1:0] cur;

    always_comb begin
        ref_age      = '0;
        cur          = '0;
        touch_o      = ages_i;
        insert_lru_o = ages_i;
        lru_way_o    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_BITS'(w) == way_i) begin
                ref_age = ages_i[w*WAY_BITS +: WAY_BITS];
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            cur = ages_i[w*WAY_BITS +: WAY_BITS];
            if (WAY_BITS'(w) == way_i) begin
                touch_o[w*WAY_BITS +: WAY_BITS]      = '0;
                insert_lru_o[w*WAY_BITS +: WAY_BITS] = AGE_LRU;
            end else begin
                if (cur < ref_age) begin
                    touch_o[w*WAY_BITS +: WAY_BITS] = cur + ONE;
                end
                if (cur > ref_age) begin
                    insert_lru_o[w*WAY_BITS +: WAY_BITS] = cur - ONE;
                end
            end
            if (cur == AGE_LRU) begin
                lru_way_o = WAY_BITS'(w);
            end
        end
    end

endmodule

// File: rtl/dip_repl_unit.sv
// DIP replacement controller: per-set true-LRU ages, LRU/BIP set dueling.
// Optional REPL_STATS_EN adds saturating leader-set miss counters.
module dip_repl_unit
    import repl_pkg::*;
#(
    parameter int  INDEX_WIDTH     = 6,
    parameter int  WAYS            = 4,
    parameter int  LEADER_BITS     = 5,
    parameter int  PSEL_WIDTH      = 10,
    parameter int  BIP_PERIOD_LOG2 = 5,
    localparam int WAY_BITS        = $clog2(WAYS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hit_valid,
    input  logic [INDEX_WIDTH-1:0] hit_index,
    input  logic [WAY_BITS-1:0]    hit_way,
    input  logic                   miss_valid,
    input  logic [INDEX_WIDTH-1:0] miss_index,
    input  logic [WAYS-1:0]        miss_way_valid,
    output logic                   victim_valid,
    output logic [WAY_BITS-1:0]    victim_way,
    input  logic                   fill_valid,
    input  logic [INDEX_WIDTH-1:0] fill_index,
    input  logic [WAY_BITS-1:0]    fill_way,
    output logic                   follower_bip,
`ifdef REPL_STATS_EN
    output logic [PSEL_WIDTH-1:0]  psel,
    output logic [31:0]            lru_leader_misses,
    output logic [31:0]            bip_leader_misses
`else
    output logic [PSEL_WIDTH-1:0]  psel
`endif
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam int AW    = WAYS * WAY_BITS;

    localparam logic [PSEL_WIDTH-1:0] PSEL_RST =
        PSEL_WIDTH'(psel_reset(PSEL_WIDTH));

    function automatic logic [AW-1:0] init_ages();
        logic [AW-1:0] r;
        r = '0;
        for (int w = 0; w < WAYS; w++) begin
            r[w*WAY_BITS +: WAY_BITS] = WAY_BITS'(w);
        end
        return r;
    endfunction

    localparam logic [AW-1:0] AGE_INIT = init_ages();

    logic [AW-1:0]              age_q [DEPTH];
    logic [PSEL_WIDTH-1:0]      psel_q, psel_d;
    logic [BIP_PERIOD_LOG2-1:0] bip_ctr_q, bip_ctr_d;
    logic                       victim_valid_q;
    logic [WAY_BITS-1:0]        victim_way_q, victim_way_d;

    logic [AW-1:0]       hit_touch, fill_touch, fill_ins, fill_new;
    logic [AW-1:0]       hit_ins_unused, miss_touch_unused, miss_ins_unused;
    logic [WAY_BITS-1:0] hit_lru_unused, fill_lru_unused, miss_lru;

    SetClass miss_class, fill_class;
    logic    fill_bip, fill_mru, hit_apply;

    assign miss_class = set_class(32'(miss_index), LEADER_BITS);
    assign fill_class = set_class(32'(fill_index), LEADER_BITS);

    lru_age_set #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_hit (
        .ages_i       (age_q[hit_index]),
        .way_i        (hit_way),
        .touch_o      (hit_touch),
        .insert_lru_o (hit_ins_unused),
        .lru_way_o    (hit_lru_unused)
    );

    lru_age_set #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_fill (
        .ages_i       (age_q[fill_index]),
        .way_i        (fill_way),
        .touch_o      (fill_touch),
        .insert_lru_o (fill_ins),
        .lru_way_o    (fill_lru_unused)
    );

    lru_age_set #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_victim (
        .ages_i       (age_q[miss_index]),
        .way_i        ('0),
        .touch_o      (miss_touch_unused),
        .insert_lru_o (miss_ins_unused),
        .lru_way_o    (miss_lru)
    );

    // Followers track the leader with fewer misses via the PSEL MSB.
    assign fill_bip = (fill_class == SET_LEADER_BIP) ||
                      ((fill_class == SET_FOLLOWER) && psel_q[PSEL_WIDTH-1]);
    assign fill_mru = !fill_bip || (bip_ctr_q == '0);
    assign fill_new = fill_mru ? fill_touch : fill_ins;

    assign hit_apply = hit_valid && !(fill_valid && (fill_index == hit_index));

    always_comb begin
        psel_d = psel_q;
        if (miss_valid) begin
            unique case (miss_class)
                SET_LEADER_LRU: begin
                    if (psel_q != '1) psel_d = psel_q + PSEL_WIDTH'(1);
                end
                SET_LEADER_BIP: begin
                    if (psel_q != '0) psel_d = psel_q - PSEL_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bip_ctr_d = bip_ctr_q;
        if (fill_valid && fill_bip) begin
            bip_ctr_d = bip_ctr_q + BIP_PERIOD_LOG2'(1);
        end
    end

    // Invalid ways are always preferred; the lowest index wins.
    always_comb begin
        victim_way_d = miss_lru;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!miss_way_valid[w]) victim_way_d = WAY_BITS'(w);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                age_q[d] <= AGE_INIT;
            end
            psel_q         <= PSEL_RST;
            bip_ctr_q      <= '0;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
        end else begin
            if (hit_apply) begin
                age_q[hit_index] <= hit_touch;
            end
            if (fill_valid) begin
                age_q[fill_index] <= fill_new;
            end
            psel_q         <= psel_d;
            bip_ctr_q      <= bip_ctr_d;
            victim_valid_q <= miss_valid;
            if (miss_valid) begin
                victim_way_q <= victim_way_d;
            end
        end
    end

    assign victim_valid = victim_valid_q;
    assign victim_way   = victim_way_q;
    assign psel         = psel_q;
    assign follower_bip = psel_q[PSEL_WIDTH-1];

`ifdef REPL_STATS_EN
    logic [31:0] lru_miss_q, bip_miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru_miss_q <= '0;
            bip_miss_q <= '0;
        end else if (miss_valid) begin
            if (miss_class == SET_LEADER_LRU && lru_miss_q != '1) begin
                lru_miss_q <= lru_miss_q + 32'd1;
            end
            if (miss_class == SET_LEADER_BIP && bip_miss_q != '1) begin
                bip_miss_q <= bip_miss_q + 32'd1;
            end
        end
    end

    assign lru_leader_misses = lru_miss_q;
    assign bip_leader_misses = bip_miss_q;
`endif

endmodule

// File: tb/tb_dip_repl_unit.sv
// Self-checking bench for dip_repl_unit: directed scenarios plus random
// traffic against a recency-list reference model.
module tb_dip_repl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       hit_valid, miss_valid, fill_valid;
    logic [5:0] hit_index, miss_index, fill_index;
    logic [1:0] hit_way, fill_way, victim_way;
    logic [3:0] miss_way_valid;
    logic       victim_valid, follower_bip;
    logic [9:0] psel;
`ifdef REPL_STATS_EN
    logic [31:0] lru_leader_misses, bip_leader_misses;
`endif

    always #5 clk = ~clk;

    dip_repl_unit #(
        .INDEX_WIDTH(6), .WAYS(4), .LEADER_BITS(5),
        .PSEL_WIDTH(10), .BIP_PERIOD_LOG2(5)
    ) dut (
        .clk(clk), .rst(rst),
        .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way),
        .miss_valid(miss_valid), .miss_index(miss_index),
        .miss_way_valid(miss_way_valid),
        .victim_valid(victim_valid), .victim_way(victim_way),
        .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way),
        .follower_bip(follower_bip),
`ifdef REPL_STATS_EN
        .lru_leader_misses(lru_leader_misses),
        .bip_leader_misses(bip_leader_misses),
`endif
        .psel(psel)
    );

    // Model: per set, the ways ordered from most to least recently used.
    int ord [64][$];
    int m_psel, m_bip, exp_vw;
    bit exp_vv;
    int n_checks = 0;
    int n_pass   = 0;

    function automatic int cls(input int idx);
        int lo;
        lo = idx % 32;
        if (lo == 0) return 1;
        if (lo == 1) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            ord[s].delete();
            for (int w = 0; w < 4; w++) ord[s].push_back(w);
        end
        m_psel = 511;
        m_bip  = 0;
        exp_vv = 0;
        exp_vw = 0;
    endtask

    task automatic move(input int s, input int w, input bit front);
        for (int k = 0; k < ord[s].size(); k++) begin
            if (ord[s][k] == w) begin
                ord[s].delete(k);
                break;
            end
        end
        if (front) ord[s].push_front(w);
        else       ord[s].push_back(w);
    endtask

    task automatic idle_inputs();
        hit_valid = 0; hit_index = 0; hit_way = 0;
        miss_valid = 0; miss_index = 0; miss_way_valid = 4'hF;
        fill_valid = 0; fill_index = 0; fill_way = 0;
    endtask

    // Drive one cycle of traffic and advance the model by the same events.
    task automatic do_cycle(input bit hv, input int hi, input int hw,
                            input bit mv, input int mi, input logic [3:0] mval,
                            input bit fv, input int fi, input int fw);
        bit bip;
        hit_valid = hv; hit_index = 6'(hi); hit_way = 2'(hw);
        miss_valid = mv; miss_index = 6'(mi); miss_way_valid = mval;
        fill_valid = fv; fill_index = 6'(fi); fill_way = 2'(fw);
        exp_vv = mv;
        if (mv) begin
            exp_vw = ord[mi][3];
            for (int w = 3; w >= 0; w--) if (!mval[w]) exp_vw = w;
        end
        bip = (cls(fi) == 2) || (cls(fi) == 0 && m_psel >= 512);
        if (hv && !(fv && fi == hi)) move(hi, hw, 1);
        if (fv) begin
            move(fi, fw, !bip || m_bip == 0);
            if (bip) m_bip = (m_bip + 1) % 32;
        end
        if (mv) begin
            if (cls(mi) == 1 && m_psel < 1023) m_psel++;
            if (cls(mi) == 2 && m_psel > 0)    m_psel--;
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (victim_valid !== 1'b0 || victim_way !== 2'd0)
            $display("FAIL reset_victim got v=%b w=%0d want v=0 w=0",
                     victim_valid, victim_way);
        else n_pass++;
        n_checks++;
        if (psel !== 10'd511 || follower_bip !== 1'b0)
            $display("FAIL reset_psel got %0d fb=%b want 511 fb=0",
                     psel, follower_bip);
        else n_pass++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_victim();
        do_cycle(0, 0, 0, 1, 2, 4'b1111, 0, 0, 0);
        n_checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd3)
            $display("FAIL victim_lru got v=%b w=%0d want v=1 w=3",
                     victim_valid, victim_way);
        else n_pass++;
        n_checks++;
        if (psel !== 10'd511 || follower_bip !== 1'b0)
            $display("FAIL follower_psel got %0d want 511", psel);
        else n_pass++;
        do_cycle(0, 0, 0, 0, 0, 4'hF, 0, 0, 0);
        n_checks++;
        if (victim_valid !== 1'b0)
            $display("FAIL victim_pulse got v=%b want 0", victim_valid);
        else n_pass++;
        do_cycle(0, 0, 0, 1, 2, 4'b1011, 0, 0, 0);
        n_checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd2)
            $display("FAIL victim_invalid got w=%0d want 2", victim_way);
        else n_pass++;
    endtask

    task automatic test_hit_order();
        do_cycle(1, 2, 3, 0, 0, 4'hF, 0, 0, 0);
        do_cycle(1, 2, 2, 0, 0, 4'hF, 0, 0, 0);
        do_cycle(1, 2, 1, 0, 0, 4'hF, 0, 0, 0);
        do_cycle(0, 0, 0, 1, 2, 4'hF, 0, 0, 0);
        n_checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd0)
            $display("FAIL hit_order got w=%0d want 0", victim_way);
        else n_pass++;
    endtask

    task automatic test_psel();
        do_cycle(0, 0, 0, 1, 0, 4'hF, 0, 0, 0);
        n_checks++;
        if (psel !== 10'd512 || follower_bip !== 1'b1)
            $display("FAIL psel_lru_leader got %0d fb=%b want 512 fb=1",
                     psel, follower_bip);
        else n_pass++;
        do_cycle(0, 0, 0, 1, 1, 4'hF, 0, 0, 0);
        n_checks++;
        if (psel !== 10'd511 || follower_bip !== 1'b0)
            $display("FAIL psel_bip_leader got %0d want 511", psel);
        else n_pass++;
        for (int i = 0; i < 600; i++) do_cycle(0, 0, 0, 1, 1, 4'hF, 0, 0, 0);
        n_checks++;
        if (psel !== 10'd0)
            $display("FAIL psel_sat_low got %0d want 0", psel);
        else n_pass++;
        for (int i = 0; i < 1100; i++) do_cycle(0, 0, 0, 1, 32, 4'hF, 0, 0, 0);
        n_checks++;
        if (psel !== 10'd1023 || follower_bip !== 1'b1)
            $display("FAIL psel_sat_high got %0d want 1023", psel);
        else n_pass++;
        for (int i = 0; i < 1100; i++) do_cycle(0, 0, 0, 1, 1, 4'hF, 0, 0, 0);
        n_checks++;
        if (psel !== 10'(m_psel))
            $display("FAIL psel_model got %0d want %0d", psel, m_psel);
        else n_pass++;
    endtask

    task automatic test_bip();
        do_cycle(0, 0, 0, 0, 0, 4'hF, 1, 33, 0);
        do_cycle(0, 0, 0, 1, 33, 4'hF, 0, 0, 0);
        n_checks++;
        if (victim_way !== 2'd3)
            $display("FAIL bip_first_mru got w=%0d want 3", victim_way);
        else n_pass++;
        do_cycle(0, 0, 0, 0, 0, 4'hF, 1, 33, 1);
        do_cycle(0, 0, 0, 1, 33, 4'hF, 0, 0, 0);
        n_checks++;
        if (victim_way !== 2'd1)
            $display("FAIL bip_lru_insert got w=%0d want 1", victim_way);
        else n_pass++;
        for (int i = 0; i < 30; i++) do_cycle(0, 0, 0, 0, 0, 4'hF, 1, 33, 2);
        do_cycle(0, 0, 0, 0, 0, 4'hF, 1, 33, 3);
        do_cycle(0, 0, 0, 1, 33, 4'hF, 0, 0, 0);
        n_checks++;
        if (victim_way !== 2'd2 || victim_way !== 2'(exp_vw))
            $display("FAIL bip_wrap_mru got w=%0d want 2", victim_way);
        else n_pass++;
    endtask

    task automatic test_hit_fill_same();
        do_cycle(1, 5, 3, 0, 0, 4'hF, 0, 0, 0);
        do_cycle(1, 5, 2, 0, 0, 4'hF, 1, 5, 1);
        do_cycle(0, 0, 0, 1, 5, 4'hF, 0, 0, 0);
        n_checks++;
        if (victim_way !== 2'd2)
            $display("FAIL fill_beats_hit got w=%0d want 2", victim_way);
        else n_pass++;
        do_cycle(1, 6, 3, 0, 0, 4'hF, 1, 7, 3);
        do_cycle(0, 0, 0, 1, 6, 4'hF, 0, 0, 0);
        n_checks++;
        if (victim_way !== 2'(exp_vw))
            $display("FAIL diff_idx_hit got w=%0d want %0d", victim_way, exp_vw);
        else n_pass++;
        do_cycle(0, 0, 0, 1, 7, 4'hF, 0, 0, 0);
        n_checks++;
        if (victim_way !== 2'(exp_vw))
            $display("FAIL diff_idx_fill got w=%0d want %0d", victim_way, exp_vw);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 2000; i++) begin
            int hi, mi, fi;
            logic [3:0] mv;
            hi = $urandom_range(0, 7) | ($urandom_range(0, 1) << 5);
            mi = $urandom_range(0, 7) | ($urandom_range(0, 1) << 5);
            fi = $urandom_range(0, 7) | ($urandom_range(0, 1) << 5);
            mv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            do_cycle($urandom_range(0, 1) == 1, hi, $urandom_range(0, 3),
                     $urandom_range(0, 1) == 1, mi, mv,
                     $urandom_range(0, 2) == 0, fi, $urandom_range(0, 3));
            n_checks++;
            if (victim_valid !== exp_vv ||
                (exp_vv && victim_way !== 2'(exp_vw))) begin
                if (errs < 10)
                    $display("FAIL rand_victim cyc %0d got v=%b w=%0d want v=%b w=%0d",
                             i, victim_valid, victim_way, exp_vv, exp_vw);
                errs++;
            end else n_pass++;
            n_checks++;
            if (psel !== 10'(m_psel) || follower_bip !== (m_psel >= 512)) begin
                if (errs < 10)
                    $display("FAIL rand_psel cyc %0d got %0d want %0d",
                             i, psel, m_psel);
                errs++;
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        do_cycle(0, 0, 0, 1, 0, 4'hF, 0, 0, 0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (victim_valid !== 1'b0 || psel !== 10'd511 || follower_bip !== 1'b0)
            $display("FAIL reset_mid got v=%b psel=%0d want v=0 psel=511",
                     victim_valid, psel);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        do_cycle(0, 0, 0, 1, 2, 4'hF, 0, 0, 0);
        n_checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd3)
            $display("FAIL reset_ages got w=%0d want 3", victim_way);
        else n_pass++;
        do_cycle(0, 0, 0, 0, 0, 4'hF, 1, 33, 1);
        do_cycle(0, 0, 0, 1, 33, 4'hF, 0, 0, 0);
        n_checks++;
        if (victim_way !== 2'd3)
            $display("FAIL reset_bip_ctr got w=%0d want 3", victim_way);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_victim();
        test_hit_order();
        test_psel();
        test_bip();
        test_hit_fill_same();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
